// File: rtl/ac97_pkg.sv
// Shared AC'97 link constants and FSM encoding, used by both the capture and transmit sides.
package ac97_pkg;

    localparam int unsigned FRAME_BITS = 256;
    localparam int unsigned SLOT0_BITS = 16;
    localparam int unsigned SLOT_BITS  = 20;

    localparam int unsigned TAG_READY = 15;
    localparam int unsigned TAG_S1    = 14;
    localparam int unsigned TAG_S2    = 13;
    localparam int unsigned TAG_S3    = 12;
    localparam int unsigned TAG_S4    = 11;

    // First bit of each slot within the 256-bit frame.
    localparam int unsigned SLOT1_START = SLOT0_BITS;
    localparam int unsigned SLOT2_START = SLOT1_START + SLOT_BITS;
    localparam int unsigned SLOT3_START = SLOT2_START + SLOT_BITS;
    localparam int unsigned SLOT4_START = SLOT3_START + SLOT_BITS;
    localparam int unsigned SLOT5_START = SLOT4_START + SLOT_BITS;

    typedef logic [1:0] ac97_state_t;

    localparam ac97_state_t StIdle    = 2'd0;
    localparam ac97_state_t StFrame   = 2'd1;
    localparam ac97_state_t StPublish = 2'd2;

    // Index of the last bit of a slot (slot 0 is the 16-bit tag).
    function automatic logic [7:0] slot_last_bit(input int unsigned slot);
        int unsigned last;
        if (slot == 0) begin
            last = SLOT0_BITS - 1;
        end else begin
            last = SLOT0_BITS + SLOT_BITS * slot - 1;
        end
        return last[7:0];
    endfunction

endpackage

// File: rtl/ac97_edge_sync.sv
// Synchronises the codec bit_clk/sync/sdata_in bundle into clk and flags bit_clk falling edges.
module ac97_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_clk,
    input  logic sync,
    input  logic sdata_in,
    output logic strobe,
    output logic sync_s,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] bclk_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sdat_q;
    logic                   bclk_prev_q;

    // All three lines share the same depth so data stays aligned to the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_q      <= '0;
            sync_q      <= '0;
            sdat_q      <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_q      <= {bclk_q[SYNC_STAGES-2:0], bit_clk};
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sync};
            sdat_q      <= {sdat_q[SYNC_STAGES-2:0], sdata_in};
            bclk_prev_q <= bclk_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        strobe  = bclk_prev_q & ~bclk_q[SYNC_STAGES-1];
        sync_s  = sync_q[SYNC_STAGES-1];
        sdata_s = sdat_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/ac97_capture_rx.sv
// AC'97 link receiver: frames codec sdata_in against sync, publishes tag, status and PCM slots.
module ac97_capture_rx
    import ac97_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_clk,
    input  logic        sync,
    input  logic        sdata_in,
    output logic        codec_ready,
    output logic [7:0]  status_addr,
    output logic [15:0] status_data,
    output logic        status_valid,
    output logic [19:0] left_data,
    output logic [19:0] right_data,
    output logic        pcm_valid,
    output logic        frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    localparam logic [7:0] BIT_TAG_END = slot_last_bit(0);
    localparam logic [7:0] BIT_S1_END  = slot_last_bit(1);
    localparam logic [7:0] BIT_S2_END  = slot_last_bit(2);
    localparam logic [7:0] BIT_S3_END  = slot_last_bit(3);
    localparam logic [7:0] BIT_S4_END  = slot_last_bit(4);
    localparam logic [7:0] BIT_LAST    = 8'(FRAME_BITS - 1);

    logic strobe;
    logic sync_s;
    logic sdata_s;

    ac97_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .bit_clk (bit_clk),
        .sync    (sync),
        .sdata_in(sdata_in),
        .strobe  (strobe),
        .sync_s  (sync_s),
        .sdata_s (sdata_s)
    );

    ac97_state_t   state_q, state_d;
    logic [7:0]    bitcnt_q, bitcnt_d;
    logic          sync_prev_q, sync_prev_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [19:0]   shift_q, shift_d;

    // Per-frame capture, held until the frame is published.
    logic [15:0]   tag_q, tag_d;
    logic [7:0]    addr_q, addr_d;
    logic [15:0]   sdat_q, sdat_d;
    logic [19:0]   left_q, left_d;
    logic [19:0]   right_q, right_d;

    logic          codec_ready_q, codec_ready_d;
    logic [7:0]    status_addr_q, status_addr_d;
    logic [15:0]   status_data_q, status_data_d;
    logic          status_valid_q, status_valid_d;
    logic [19:0]   left_data_q, left_data_d;
    logic [19:0]   right_data_q, right_data_d;
    logic          pcm_valid_q, pcm_valid_d;
    logic          frame_err_q, frame_err_d;

    logic          sync_rise;
    logic          timeout;
    logic [19:0]   shift_in;
    logic [7:0]    bit_idx;

    always_comb begin
        sync_rise = strobe & sync_s & ~sync_prev_q;
        timeout   = (state_q != StIdle) && (tmo_q == TMO_MAX);
        shift_in  = {shift_q[18:0], sdata_s};
        // An early sync rise restarts the frame on this very bit.
        bit_idx   = sync_rise ? 8'd0 : bitcnt_q;
    end

    always_comb begin
        state_d        = state_q;
        bitcnt_d       = bitcnt_q;
        sync_prev_d    = sync_prev_q;
        tmo_d          = tmo_q;
        shift_d        = shift_q;
        tag_d          = tag_q;
        addr_d         = addr_q;
        sdat_d         = sdat_q;
        left_d         = left_q;
        right_d        = right_q;
        codec_ready_d  = codec_ready_q;
        status_addr_d  = status_addr_q;
        status_data_d  = status_data_q;
        status_valid_d = 1'b0;
        left_data_d    = left_data_q;
        right_data_d   = right_data_q;
        pcm_valid_d    = 1'b0;
        frame_err_d    = 1'b0;

        if (strobe) begin
            sync_prev_d = sync_s;
            tmo_d       = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (timeout) begin
            frame_err_d   = 1'b1;
            codec_ready_d = 1'b0;
            state_d       = StIdle;
            bitcnt_d      = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sync_rise) begin
                        shift_d  = shift_in;
                        bitcnt_d = 8'd1;
                        state_d  = StFrame;
                    end
                end

                StFrame: begin
                    if (strobe) begin
                        if (bitcnt_q == 8'd0 && !sync_rise) begin
                            frame_err_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            if (sync_rise && bitcnt_q != 8'd0) begin
                                frame_err_d = 1'b1;
                            end
                            shift_d  = shift_in;
                            bitcnt_d = bit_idx + 8'd1;
                            if (bit_idx == BIT_TAG_END) tag_d   = shift_in[15:0];
                            if (bit_idx == BIT_S1_END)  addr_d  = shift_in[19:12];
                            if (bit_idx == BIT_S2_END)  sdat_d  = shift_in[19:4];
                            if (bit_idx == BIT_S3_END)  left_d  = shift_in;
                            if (bit_idx == BIT_S4_END)  right_d = shift_in;
                            if (bit_idx == BIT_LAST)    state_d = StPublish;
                        end
                    end
                end

                StPublish: begin
                    codec_ready_d = tag_q[TAG_READY];
                    if (tag_q[TAG_S1] && tag_q[TAG_S2]) begin
                        status_addr_d  = addr_q;
                        status_data_d  = sdat_q;
                        status_valid_d = 1'b1;
                    end
                    // A half-valid stereo pair is dropped entirely.
                    if (tag_q[TAG_S3] && tag_q[TAG_S4]) begin
                        left_data_d  = left_q;
                        right_data_d = right_q;
                        pcm_valid_d  = 1'b1;
                    end
                    bitcnt_d = 8'd0;
                    state_d  = StFrame;
                end

                default: begin
                    state_d  = StIdle;
                    bitcnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            bitcnt_q       <= 8'd0;
            sync_prev_q    <= 1'b0;
            tmo_q          <= '0;
            shift_q        <= '0;
            tag_q          <= '0;
            addr_q         <= '0;
            sdat_q         <= '0;
            left_q         <= '0;
            right_q        <= '0;
            codec_ready_q  <= 1'b0;
            status_addr_q  <= '0;
            status_data_q  <= '0;
            status_valid_q <= 1'b0;
            left_data_q    <= '0;
            right_data_q   <= '0;
            pcm_valid_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            sync_prev_q    <= sync_prev_d;
            tmo_q          <= tmo_d;
            shift_q        <= shift_d;
            tag_q          <= tag_d;
            addr_q         <= addr_d;
            sdat_q         <= sdat_d;
            left_q         <= left_d;
            right_q        <= right_d;
            codec_ready_q  <= codec_ready_d;
            status_addr_q  <= status_addr_d;
            status_data_q  <= status_data_d;
            status_valid_q <= status_valid_d;
            left_data_q    <= left_data_d;
            right_data_q   <= right_data_d;
            pcm_valid_q    <= pcm_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    always_comb begin
        codec_ready  = codec_ready_q;
        status_addr  = status_addr_q;
        status_data  = status_data_q;
        status_valid = status_valid_q;
        left_data    = left_data_q;
        right_data   = right_data_q;
        pcm_valid    = pcm_valid_q;
        frame_err    = frame_err_q;
    end

endmodule

// File: doc/ac97_capture_rx.md
Name: ac97_capture_rx

Overview:
- AC'97 link receiver: deserializes codec `sdata_in` into 256-bit frames, aligned to the link `sync` driven by our audio_controller.
- Extracts the slot-0 tag, the slot-1/2 status register readback and the slot-3/4 left/right 20-bit PCM capture samples.
- Runs entirely on the system clock `clk` (100 MHz). `bit_clk`, `sync` and `sdata_in` are treated as asynchronous inputs and oversampled.
- Sits beside audio_controller in top_level. Feeds the capture FIFO and the register-read path of audio_cmd.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on bit_clk/sync/sdata_in before use (minimum 2).
- TIMEOUT, 64, clk cycles without a bit_clk falling edge before the link is declared dead.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- bit_clk  in  1  12.288 MHz codec bit clock (asynchronous)
- sync  in  1  frame sync, as driven to the codec (asynchronous)
- sdata_in  in  1  codec serial data (asynchronous)
- codec_ready  out  1  slot-0 tag bit 15 of last complete frame
- status_addr  out  8  slot-1 bits 19:12
- status_data  out  16  slot-2 bits 19:4
- status_valid  out  1  one-cycle pulse: new status word
- left_data  out  20  slot-3 PCM sample
- right_data  out  20  slot-4 PCM sample
- pcm_valid  out  1  one-cycle pulse: left/right updated
- frame_err  out  1  one-cycle pulse: sync misaligned or link timeout

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, counters 0.
- Input synchronisation: `bit_clk`, `sync` and `sdata_in` each pass through SYNC_STAGES flops.
- Sample strobe: a bit_clk falling edge (synced previous = 1, current = 0) produces a one-cycle strobe. `sync` and `sdata_in` are sampled only on this strobe.
- Bit counter `bitcnt` (0..255):
  - Slot 0 = bits 0..15.
  - Slot n (1..12) = bits 16+20(n-1) .. 35+20(n-1).
  - Shift in MSB first.
- FSM states and transitions:
  - IDLE:
    - On a strobe with sampled sync = 1 and previous sampled sync = 0, that strobe's data bit is tag bit 15 (bitcnt = 0).
    - Go to FRAME.
  - FRAME:
    - Capture tag[15:0] at bits 0..15.
    - Capture slot1 at bits 16..35, slot2 at bits 36..55.
    - Capture left at bits 56..75, right at bits 76..95.
    - Bits 96..255 are ignored.
    - On the strobe that samples bit 255, go to PUBLISH.
  - PUBLISH (exactly one clk):
    - `codec_ready` <= tag[15].
    - If tag[14] & tag[13]: load `status_addr`/`status_data`, pulse `status_valid`.
    - If tag[12] & tag[11]: load `left_data`/`right_data`, pulse `pcm_valid`.
    - If only one of tag[12]/tag[11] is set: neither PCM register is updated and no pulse is issued.
    - Return to FRAME with bitcnt = 0, expecting the next sync rising edge on the next strobe.
- Output latency: outputs change and pulses fire on the clk after the strobe sampling bit 255. Non-updated outputs hold their value.
- Sync alignment checks:
  - A sync rising edge seen in FRAME at bitcnt != 0: pulse `frame_err`, discard the partial frame, treat that strobe as bit 0 of a new frame.
  - A missing sync rising edge at bitcnt = 0 in FRAME: pulse `frame_err`, go to IDLE.
- Link timeout:
  - A counter counts clk cycles since the last strobe and saturates at TIMEOUT.
  - On reaching TIMEOUT in any non-IDLE state: pulse `frame_err` once, clear `codec_ready`, go to IDLE.
- Reset mid-frame: immediate return to reset state. No pulses are issued for the partial frame.
- Simultaneous events: `rst` dominates, then timeout, then sync error.

Decomposition:
- Shared package ac97_pkg, holding:
  - FRAME_BITS = 256, SLOT0_BITS = 16, SLOT_BITS = 20.
  - Tag bit indices: TAG_READY = 15, TAG_S1 = 14, TAG_S2 = 13, TAG_S3 = 12, TAG_S4 = 11.
  - Slot start offsets.
  - Typedef for the FSM state enum.
  - The same constants feed the existing transmit side.
- One sub-module, ac97_edge_sync: SYNC_STAGES synchroniser plus falling-edge strobe. Instantiated once for the bit_clk/sync/sdata_in bundle.

Test Plan:
- Basic capture:
  - Stimulus: frame with tag 16'hF800, slot1 20'h26000, slot2 20'h000F0, left 20'h0C8BD, right 20'hF3743.
  - Response: codec_ready = 1; status_addr = 8'h26, status_data = 16'h000F, status_valid one pulse; left_data = 20'h0C8BD, right_data = 20'hF3743, pcm_valid one pulse.
- Tag without valid bits:
  - Stimulus: tag 16'h8000.
  - Response: codec_ready = 1; no status_valid or pcm_valid; data outputs hold prior values.
- Partial PCM tag:
  - Stimulus: tag 16'h9000 (only slot 3 valid).
  - Response: no pcm_valid; left_data and right_data unchanged.
- Early sync:
  - Stimulus: sync rising edge at bitcnt = 100.
  - Response: frame_err one pulse, no publish; the next complete frame (tag 16'hF800) publishes correctly.
- Link timeout:
  - Stimulus: stop bit_clk for 64+ clk cycles mid-frame.
  - Response: frame_err one pulse, codec_ready -> 0; the next valid frame recovers.
- Reset mid-frame:
  - Stimulus: assert rst at bitcnt = 60 for one clk.
  - Response: all outputs 0 on the next clk, no pulses; first full frame after reset captures normally.
